// File: rtl/hash_msg_feeder.sv
// Transmit-side driver for the DES-S-box hash core input interface.
// Takes a length command plus an upstream byte stream, paces one m_valid pulse
// per byte with GAP_CYCLES idle cycles between pulses, then waits for a rising
// edge on hash_ready to capture the digest (or times out).
module hash_msg_feeder #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [63:0] cmd_len,
  output logic        cmd_ready,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_message,
  output logic [63:0] m_counter,
  input  logic        hash_ready,
  input  logic [31:0] digest_in,
  output logic [31:0] digest_out,
  output logic        done,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES);
  // Last WAIT cycle index before the timeout fires.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TO_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_message_q, m_message_d;
  logic [63:0] m_counter_q, m_counter_d;
  logic [31:0] digest_q, digest_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;
  logic        hr_q;
  logic [63:0] rem_q, rem_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        hr_rise;

  // Only a fresh rising edge of hash_ready counts as completion; a level left
  // high from a previous message must not complete the current one.
  assign hr_rise = hash_ready && !hr_q;

  // Next-state and registered-output computation for the feeder FSM.
  always_comb begin
    state_d       = state_q;
    m_valid_d     = 1'b0;
    m_message_d   = m_message_q;
    m_counter_d   = m_counter_q;
    digest_d      = digest_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    rem_d         = rem_q;
    gap_cnt_d     = gap_cnt_q;
    to_cnt_d      = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          m_counter_d   = cmd_len;
          rem_d         = cmd_len;
          timeout_err_d = 1'b0;
          to_cnt_d      = 16'd0;
          if (cmd_len == 64'd0) begin
            // Empty message: the core still needs one pulse to start.
            m_valid_d   = 1'b1;
            m_message_d = 8'h00;
            state_d     = WAIT;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (s_valid) begin
          m_valid_d   = 1'b1;
          m_message_d = s_data;
          rem_d       = rem_q - 64'd1;
          gap_cnt_d   = GAP_LOAD;
          if (rem_q == 64'd1) begin
            to_cnt_d = 16'd0;
            state_d  = WAIT;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      WAIT: begin
        // Edge wins over an expiring count in the same cycle.
        if (hr_rise) begin
          digest_d = digest_in;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (to_cnt_q >= TO_LAST) begin
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and core-facing outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      m_valid_q     <= 1'b0;
      m_message_q   <= 8'h00;
      m_counter_q   <= 64'd0;
      digest_q      <= 32'd0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      hr_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_message_q   <= m_message_d;
      m_counter_q   <= m_counter_d;
      digest_q      <= digest_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      hr_q          <= hash_ready;
    end
  end

  // Working counters; always loaded before they are read, so no reset needed.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    gap_cnt_q <= gap_cnt_d;
    to_cnt_q  <= to_cnt_d;
  end

  assign cmd_ready   = (state_q == IDLE);
  assign s_ready     = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign m_valid     = m_valid_q;
  assign m_message   = m_message_q;
  assign m_counter   = m_counter_q;
  assign digest_out  = digest_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed testbench for hash_msg_feeder (GAP_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_hash_msg_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [63:0] cmd_len = 64'd0;
  logic        cmd_ready;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_message;
  logic [63:0] m_counter;
  logic        hash_ready = 1'b0;
  logic [31:0] digest_in = 32'd0;
  logic [31:0] digest_out;
  logic        done;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  hash_msg_feeder #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_message(m_message), .m_counter(m_counter),
    .hash_ready(hash_ready), .digest_in(digest_in), .digest_out(digest_out),
    .done(done), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    n_checks++; if (m_message !== 8'h00) begin n_fail++; $display("FAIL reset_m_message got %h exp 00", m_message); end
    n_checks++; if (m_counter !== 64'd0) begin n_fail++; $display("FAIL reset_m_counter got %h exp 0", m_counter); end
    n_checks++; if (digest_out !== 32'd0) begin n_fail++; $display("FAIL reset_digest got %h exp 0", digest_out); end
    n_checks++; if (done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_done_to got %b%b exp 00", done, timeout_err); end
    n_checks++; if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hs got cr=%b sr=%b busy=%b exp 1 0 0", cmd_ready, s_ready, busy); end
    rst_n = 1'b1;
    tick();
  endtask

  // Three bytes, always valid: pulses at cycles 2,5,8; edge at 10, done at 11.
  task automatic test_basic();
    logic [7:0] bytes [4];
    int idx;
    bytes[0] = 8'h61; bytes[1] = 8'h62; bytes[2] = 8'h63; bytes[3] = 8'hEE;
    idx = 0;
    digest_in = 32'hDEADBEEF;
    cmd_len = 64'd3;
    cmd_valid = 1'b1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      s_valid = 1'b1;
      s_data = bytes[idx];
      hash_ready = (c == 10 || c == 11);
      n_checks++; if (m_valid !== (c == 2 || c == 5 || c == 8)) begin n_fail++; $display("FAIL basic_m_valid c=%0d got %b", c, m_valid); end
      if (c == 2 || c == 5 || c == 8) begin
        n_checks++; if (m_message !== bytes[(c - 2) / 3]) begin n_fail++; $display("FAIL basic_m_message c=%0d got %h exp %h", c, m_message, bytes[(c - 2) / 3]); end
      end
      n_checks++; if (s_ready !== (c == 1 || c == 4 || c == 7)) begin n_fail++; $display("FAIL basic_s_ready c=%0d got %b", c, s_ready); end
      n_checks++; if (m_counter !== 64'd3) begin n_fail++; $display("FAIL basic_m_counter c=%0d got %0d exp 3", c, m_counter); end
      n_checks++; if (busy !== (c <= 10)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
      n_checks++; if (done !== (c == 11)) begin n_fail++; $display("FAIL basic_done c=%0d got %b", c, done); end
      if (c == 11) begin
        n_checks++; if (digest_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_digest got %h exp DEADBEEF", digest_out); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL basic_timeout_err got %b exp 0", timeout_err); end
      end
      if (s_valid && s_ready) idx++;
      tick();
    end
    s_valid = 1'b0;
    hash_ready = 1'b0;
  endtask

  // Zero-length message: one pulse of 00, bytes offered upstream never taken.
  task automatic test_zero_len();
    cmd_len = 64'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    digest_in = 32'h12345678;
    for (int c = 1; c <= 6; c++) begin
      s_valid = 1'b1;
      s_data = 8'h99;
      hash_ready = (c == 3 || c == 4);
      n_checks++; if (m_valid !== (c == 1)) begin n_fail++; $display("FAIL zero_m_valid c=%0d got %b", c, m_valid); end
      n_checks++; if (m_message !== 8'h00) begin n_fail++; $display("FAIL zero_m_message c=%0d got %h exp 00", c, m_message); end
      n_checks++; if (m_counter !== 64'd0) begin n_fail++; $display("FAIL zero_m_counter c=%0d got %0d exp 0", c, m_counter); end
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL zero_s_ready c=%0d got %b exp 0", c, s_ready); end
      n_checks++; if (done !== (c == 4)) begin n_fail++; $display("FAIL zero_done c=%0d got %b", c, done); end
      if (c >= 4) begin
        n_checks++; if (digest_out !== 32'h12345678) begin n_fail++; $display("FAIL zero_digest c=%0d got %h exp 12345678", c, digest_out); end
      end
      tick();
    end
    s_valid = 1'b0;
    hash_ready = 1'b0;
  endtask

  // Two bytes with a 10-cycle upstream stall after the first; hash_ready is
  // left high at the end for the next scenario.
  task automatic test_stall();
    cmd_len = 64'd2;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    digest_in = 32'hCAFEF00D;
    for (int c = 1; c <= 17; c++) begin
      s_valid = (c == 1 || c == 12);
      s_data = (c < 12) ? 8'hA1 : 8'hA2;
      hash_ready = (c >= 15);
      n_checks++; if (m_valid !== (c == 2 || c == 13)) begin n_fail++; $display("FAIL stall_m_valid c=%0d got %b", c, m_valid); end
      if (c >= 2) begin
        n_checks++; if (m_message !== ((c < 13) ? 8'hA1 : 8'hA2)) begin n_fail++; $display("FAIL stall_m_message c=%0d got %h", c, m_message); end
      end
      n_checks++; if (s_ready !== (c == 1 || (c >= 4 && c <= 12))) begin n_fail++; $display("FAIL stall_s_ready c=%0d got %b", c, s_ready); end
      n_checks++; if (done !== (c == 16)) begin n_fail++; $display("FAIL stall_done c=%0d got %b", c, done); end
      if (c >= 16) begin
        n_checks++; if (digest_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stall_digest c=%0d got %h exp CAFEF00D", c, digest_out); end
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  // hash_ready still high from the previous message must not complete this one.
  task automatic test_level_held();
    cmd_len = 64'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      s_valid = (c == 1);
      s_data = 8'hB1;
      hash_ready = (c <= 5 || c >= 8);
      digest_in = (c <= 5) ? 32'hBAD0BAD0 : 32'h55AA33CC;
      n_checks++; if (m_valid !== (c == 2)) begin n_fail++; $display("FAIL held_m_valid c=%0d got %b", c, m_valid); end
      n_checks++; if (done !== (c == 9)) begin n_fail++; $display("FAIL held_done c=%0d got %b", c, done); end
      n_checks++; if (busy !== (c <= 8)) begin n_fail++; $display("FAIL held_busy c=%0d got %b", c, busy); end
      n_checks++; if (digest_out !== ((c >= 9) ? 32'h55AA33CC : 32'hCAFEF00D)) begin n_fail++; $display("FAIL held_digest c=%0d got %h", c, digest_out); end
      tick();
    end
    s_valid = 1'b0;
    hash_ready = 1'b0;
  endtask

  // No completion: timeout 16 cycles after WAIT entry (cycle 2 -> 18).
  task automatic test_timeout();
    cmd_len = 64'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    digest_in = 32'h0000FFFF;
    for (int c = 1; c <= 20; c++) begin
      s_valid = (c == 1);
      s_data = 8'hC1;
      n_checks++; if (done !== (c == 18)) begin n_fail++; $display("FAIL to_done c=%0d got %b", c, done); end
      n_checks++; if (timeout_err !== (c >= 18)) begin n_fail++; $display("FAIL to_err c=%0d got %b", c, timeout_err); end
      n_checks++; if (busy !== (c <= 17)) begin n_fail++; $display("FAIL to_busy c=%0d got %b", c, busy); end
      n_checks++; if (digest_out !== 32'h55AA33CC) begin n_fail++; $display("FAIL to_digest c=%0d got %h exp 55AA33CC", c, digest_out); end
      tick();
    end
    s_valid = 1'b0;
    // Next command clears the error level.
    cmd_len = 64'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    digest_in = 32'h0F0F0F0F;
    for (int c = 1; c <= 4; c++) begin
      hash_ready = (c == 2);
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear c=%0d got %b exp 0", c, timeout_err); end
      n_checks++; if (done !== (c == 3)) begin n_fail++; $display("FAIL to_next_done c=%0d got %b", c, done); end
      tick();
    end
    hash_ready = 1'b0;
  endtask

  // Reset pulse mid-message returns everything to idle.
  task automatic test_reset_mid();
    cmd_len = 64'd5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hD1;
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (m_valid !== (c == 2)) begin n_fail++; $display("FAIL rmid_m_valid c=%0d got %b", c, m_valid); end
      if (c == 4) begin
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_send got %b exp 1", s_ready); end
        rst_n = 1'b0;
      end
      tick();
    end
    rst_n = 1'b1;
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_state got cr=%b busy=%b sr=%b exp 1 0 0", cmd_ready, busy, s_ready); end
    n_checks++; if (m_valid !== 1'b0 || m_message !== 8'h00 || m_counter !== 64'd0) begin n_fail++; $display("FAIL rmid_core_if got %b %h %h exp 0 00 0", m_valid, m_message, m_counter); end
    n_checks++; if (digest_out !== 32'd0 || done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rmid_result got %h %b %b exp 0 0 0", digest_out, done, timeout_err); end
    tick();
    s_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after got mv=%b cr=%b exp 0 1", m_valid, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_level_held();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
